eth_frame_tx: RTL and testbench

Transmit-side counterpart of the receiver's header parser. It generates complete Ethernet frames as an 8-bit AXI4-Stream for the tri-mode MAC TX client port. Each frame is a 14-byte header (destination MAC, source MAC, length/type) followed by an incrementing-byte payload of programmable length. It sits between the pattern-generator control logic and the MAC TX interface.

---
 rtl/eth_frame_tx.sv | 172 +++++++++++++++++
 tb/tb_eth_frame_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_tx.sv
// Ethernet frame generator: 14-byte header plus incrementing payload on an 8-bit AXI4-Stream.
// Define ETH_TX_IFG_EN to insert IFG_CYCLES idle cycles (GAP state) after each frame.
module eth_frame_tx #(
    parameter logic [47:0] DEST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h5A01_0203_0405,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] payload_len,
    output logic [7:0]  tdata,
    output logic        tvalid,
    input  logic        tready,
    output logic        tlast,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int unsigned HDR_LAST = 13;
    localparam int unsigned MAX_LEN  = 1500;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD
`ifdef ETH_TX_IFG_EN
        ,
        S_GAP
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  tdata_d;
    logic        tvalid_d, tlast_d, busy_d, frame_done_d;
    logic [15:0] frame_count_d;
    logic        handshake;
`ifdef ETH_TX_IFG_EN
    logic [7:0]  gap_cnt_q, gap_cnt_d;
`endif

    // Values outside 1..255 leave a marker block in the elaborated hierarchy.
    if (IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_ifg_cycles_out_of_range
    end

    // Header byte idx of {DEST_MAC, SRC_MAC, length}, byte 0 being the MSB.
    function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [15:0] len);
        logic [111:0] hdr;
        hdr = {DEST_MAC, SRC_MAC, len};
        return 8'(hdr >> (8 * (HDR_LAST - 32'(idx))));
    endfunction

    assign handshake = tvalid & tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hdr_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            len_q       <= 16'd1;
            tdata       <= '0;
            tvalid      <= 1'b0;
            tlast       <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
`ifdef ETH_TX_IFG_EN
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            len_q       <= len_d;
            tdata       <= tdata_d;
            tvalid      <= tvalid_d;
            tlast       <= tlast_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
            frame_count <= frame_count_d;
`ifdef ETH_TX_IFG_EN
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    // Next-state and next-output logic; every output is the registered copy of a *_d value.
    always_comb begin
        state_d       = state_q;
        hdr_cnt_d     = hdr_cnt_q;
        pay_cnt_d     = pay_cnt_q;
        len_d         = len_q;
        tdata_d       = tdata;
        tvalid_d      = tvalid;
        tlast_d       = tlast;
        busy_d        = busy;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count;
`ifdef ETH_TX_IFG_EN
        gap_cnt_d     = gap_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_HDR;
                    hdr_cnt_d = '0;
                    if (payload_len == 16'd0) begin
                        len_d = 16'd1;
                    end else if (payload_len > 16'(MAX_LEN)) begin
                        len_d = 16'(MAX_LEN);
                    end else begin
                        len_d = payload_len;
                    end
                    tdata_d  = DEST_MAC[47:40];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_HDR: begin
                if (handshake) begin
                    if (hdr_cnt_q == 4'(HDR_LAST)) begin
                        state_d   = S_PAYLOAD;
                        pay_cnt_d = '0;
                        tdata_d   = 8'h00;
                        tlast_d   = (len_q == 16'd1);
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 4'd1;
                        tdata_d   = hdr_byte(hdr_cnt_d, len_q);
                    end
                end
            end
            S_PAYLOAD: begin
                if (handshake) begin
                    if (tlast) begin
                        tvalid_d      = 1'b0;
                        tlast_d       = 1'b0;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count + 16'd1;
`ifdef ETH_TX_IFG_EN
                        state_d       = S_GAP;
                        gap_cnt_d     = '0;
`else
                        state_d       = S_IDLE;
                        busy_d        = 1'b0;
`endif
                    end else begin
                        pay_cnt_d = pay_cnt_q + 16'd1;
                        tdata_d   = pay_cnt_d[7:0];
                        tlast_d   = (pay_cnt_d == len_q - 16'd1);
                    end
                end
            end
`ifdef ETH_TX_IFG_EN
            S_GAP: begin
                if (gap_cnt_q == 8'(IFG_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Randomized bench for eth_frame_tx: accepted bytes are compared with a frame model built from the frame rules.
module tb_eth_frame_tx;

    localparam logic [47:0] DEST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC  = 48'h5A01_0203_0405;
    localparam int          IFG  = 12;
`ifdef ETH_TX_IFG_EN
    localparam int  GAP_IDLE  = IFG + 1;
    localparam bit  GAP_BUSY  = 1'b1;
`else
    localparam int  GAP_IDLE  = 1;
    localparam bit  GAP_BUSY  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] payload_len;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    int vectors = 0;
    int errors  = 0;
    int exp_count = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    eth_frame_tx #(
        .DEST_MAC  (DEST),
        .SRC_MAC   (SRC),
        .IFG_CYCLES(IFG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .payload_len(payload_len),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tready     (tready),
        .tlast      (tlast),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_count(frame_count)
    );

    function automatic int clamp_len(input int plen);
        if (plen == 0) return 1;
        if (plen > 1500) return 1500;
        return plen;
    endfunction

    // Whole frame as a byte list: dest, src, length field, then i mod 256.
    function automatic void build_expected(input int plen);
        int l;
        l = clamp_len(plen);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(DEST >> (40 - 8 * i)));
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(SRC >> (40 - 8 * i)));
        exp_q.push_back(8'(l / 256));
        exp_q.push_back(8'(l % 256));
        for (int i = 0; i < l; i++) exp_q.push_back(8'(i % 256));
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    // One frame from IDLE; ready_pct sets tready density, noise wiggles start/payload_len mid-frame.
    task automatic run_frame(input int plen, input int ready_pct, input bit noise, input bit check_timing);
        int got = 0;
        int cycles = 0;
        bit done = 1'b0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_d = 8'h00;
        logic prev_l = 1'b0;
        bit exp_last;
        build_expected(plen);
        @(negedge clk);
        payload_len = 16'(plen);
        start = 1'b1;
        tready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || tvalid !== 1'b1 || tdata !== exp_q[0]) begin
            errors++;
            $display("FAIL start_latency: busy=%b tvalid=%b tdata=%h, required 1 1 %h", busy, tvalid, tdata, exp_q[0]);
        end
        while (!done && cycles < 8000) begin
            if (prev_stall) begin
                vectors++;
                if (tvalid !== 1'b1 || tdata !== prev_d || tlast !== prev_l) begin
                    errors++;
                    $display("FAIL stall_hold: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                             tvalid, tdata, tlast, prev_d, prev_l);
                end
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                payload_len = 16'($urandom);
            end
            tready = ($urandom_range(0, 99) < ready_pct);
            if (tvalid && tready) begin
                exp_last = (got == exp_q.size() - 1);
                vectors++;
                if (got >= exp_q.size() || tdata !== exp_q[got] || tlast !== exp_last) begin
                    errors++;
                    $display("FAIL frame_byte[%0d]: tdata=%h tlast=%b, required %h %b",
                             got, tdata, tlast, (got < exp_q.size()) ? exp_q[got] : 8'h00, exp_last);
                end
                if (exp_last) begin
                    done = 1'b1;
                    start = 1'b0;
                end
                got++;
            end
            prev_stall = tvalid && !tready;
            prev_d = tdata;
            prev_l = tlast;
            cycles++;
            @(negedge clk);
        end
        tready = 1'b0;
        start = 1'b0;
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL frame_timeout: %0d of %0d bytes accepted", got, exp_q.size());
        end
        exp_count++;
        vectors++;
        if (frame_done !== 1'b1 || frame_count !== 16'(exp_count) || tvalid !== 1'b0 || busy !== GAP_BUSY) begin
            errors++;
            $display("FAIL frame_end: done=%b count=%0d tvalid=%b busy=%b, required 1 %0d 0 %b",
                     frame_done, frame_count, tvalid, busy, exp_count, GAP_BUSY);
        end
        if (check_timing) begin
            vectors++;
            if (cycles != 14 + clamp_len(plen)) begin
                errors++;
                $display("FAIL frame_cycles: %0d, required %0d", cycles, 14 + clamp_len(plen));
            end
        end
        @(negedge clk);
        vectors++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: frame_done=%b, required 0", frame_done);
        end
        wait_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        tready = 1'b0;
        payload_len = 16'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 8'h00 || busy !== 1'b0 ||
            frame_done !== 1'b0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: tvalid=%b tlast=%b tdata=%h busy=%b done=%b count=%0d, required all 0",
                     tvalid, tlast, tdata, busy, frame_done, frame_count);
        end
        rst = 1'b0;
        exp_count = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_frame(4, 100, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        run_frame(300, 50, 1'b0, 1'b0);
    endtask

    task automatic test_len_bounds();
        run_frame(0, 100, 1'b0, 1'b1);
        run_frame(1, 80, 1'b0, 1'b0);
        run_frame(2000, 70, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_inputs();
        run_frame(25, 60, 1'b1, 1'b0);
        run_frame(int'($urandom_range(2, 40)), 75, 1'b1, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 4; k++) run_frame(int'($urandom_range(1, 80)), int'($urandom_range(30, 100)), 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        build_expected(20);
        @(negedge clk);
        payload_len = 16'd20;
        start = 1'b1;
        tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        vectors++;
        if (tvalid !== 1'b1 || tdata !== exp_q[7]) begin
            errors++;
            $display("FAIL pre_reset_byte: tvalid=%b tdata=%h, required 1 %h", tvalid, tdata, exp_q[7]);
        end
        rst = 1'b1;
        #1;
        exp_count = 0;
        vectors++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || tlast !== 1'b0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_frame: tvalid=%b busy=%b tlast=%b count=%0d, required 0 0 0 0",
                     tvalid, busy, tlast, frame_count);
        end
        @(negedge clk);
        rst = 1'b0;
        tready = 1'b0;
        @(negedge clk);
        vectors++;
        if (frame_done !== 1'b0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL truncated_frame: done=%b count=%0d, required 0 0", frame_done, frame_count);
        end
        run_frame(5, 100, 1'b0, 1'b1);
    endtask

    // start held high across two frames; measures tvalid-low and busy-low cycles in between.
    task automatic test_back_to_back();
        int phase = 0;
        int idle_run = 0;
        int busy_low = 0;
        int gap = -1;
        int cycles = 0;
        bit done = 1'b0;
        @(negedge clk);
        payload_len = 16'd3;
        start = 1'b1;
        tready = 1'b1;
        while (!done && cycles < 300) begin
            if (tvalid) begin
                if (phase == 1) begin
                    gap = idle_run;
                    phase = 2;
                    start = 1'b0;
                    vectors++;
                    if (tdata !== DEST[47:40]) begin
                        errors++;
                        $display("FAIL b2b_first_byte: tdata=%h, required %h", tdata, DEST[47:40]);
                    end
                end else if (phase == 0 && tlast) begin
                    phase = 1;
                end else if (phase == 2 && tlast) begin
                    done = 1'b1;
                end
            end else if (phase == 1) begin
                idle_run++;
                if (!busy) busy_low++;
            end
            cycles++;
            @(negedge clk);
        end
        tready = 1'b0;
        start = 1'b0;
        exp_count += 2;
        vectors++;
        if (!done || gap != GAP_IDLE || busy_low != 1) begin
            errors++;
            $display("FAIL b2b_gap: done=%b idle_cycles=%0d busy_low=%0d, required 1 %0d 1",
                     done, gap, busy_low, GAP_IDLE);
        end
        vectors++;
        if (frame_count !== 16'(exp_count) || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count: count=%0d done=%b, required %0d 1", frame_count, frame_done, exp_count);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_len_bounds();
        test_ignore_inputs();
        test_random_frames();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
